// File: rtl/i2s_audio_tx_pkg.sv
// Shared types and default geometry for the I2S audio transmitter.
package i2s_audio_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int I2S_SAMPLE_BITS = 16;
  localparam int I2S_BCLK_DIV    = 4;

endpackage

// File: rtl/i2s_audio_tx_audio_sat.sv
// Arithmetic right shift of a signed FIFO word followed by saturation to SAMPLE_BITS.
module audio_sat #(
  parameter int DATA_WIDTH  = 32,
  parameter int SAMPLE_BITS = 16,
  parameter int SHIFT       = 0
) (
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [SAMPLE_BITS-1:0] dout
);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] shifted;

  // NOTE: dout is assigned on every branch so this stays purely combinational (no latch).
  always_comb begin
    shifted = $signed(din) >>> SHIFT;
    if (shifted > SAT_MAX)
      dout = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    else if (shifted < SAT_MIN)
      dout = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    else
      dout = shifted[SAMPLE_BITS-1:0];
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S master transmitter: pops stereo pairs from two FWFT audio FIFOs and serialises them.
// Define I2S_UNDERFLOW_HOLD_EN to re-send the previous pair on underflow instead of silence.
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
  parameter int SHIFT       = 0,
  parameter int BCLK_DIV    = I2S_BCLK_DIV
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  busy,
  output logic                  underflow
);
  localparam int FRAME_BITS = 2 * SAMPLE_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] HALF_SLOT = CNT_W'(SAMPLE_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic [FRAME_BITS-1:0]  pair;
  logic [SAMPLE_BITS-1:0] left_s;
  logic [SAMPLE_BITS-1:0] right_s;
  logic                   stopping;
  logic                   wrap;
  logic                   tick;
  logic                   frame_end;
  logic                   pair_ready;

  audio_sat #(.DATA_WIDTH(DATA_WIDTH), .SAMPLE_BITS(SAMPLE_BITS), .SHIFT(SHIFT))
    u_left_sat (.din(left_in), .dout(left_s));

  audio_sat #(.DATA_WIDTH(DATA_WIDTH), .SAMPLE_BITS(SAMPLE_BITS), .SHIFT(SHIFT))
    u_right_sat (.din(right_in), .dout(right_s));

  always_comb begin
    wrap       = (div_cnt == DIV_LAST);
    tick       = wrap && i2s_bclk;
    frame_end  = (bit_cnt == LAST_SLOT);
    pair_ready = !left_empty && !right_empty;
    next_cnt   = frame_end ? '0 : bit_cnt + 1'b1;
  end

  // The bit sent in the slot after bit_cnt is pair[LAST_SLOT-bit_cnt]; at the frame end
  // that index is 0, i.e. the previous R LSB lands in the new slot 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      pair        <= '0;
      stopping    <= 1'b0;
      left_rd_en  <= 1'b0;
      right_rd_en <= 1'b0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      busy        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      // NOTE: pops default low every cycle, so a read enable can never stretch past one clock.
      left_rd_en  <= 1'b0;
      right_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          bit_cnt   <= '0;
          i2s_bclk  <= 1'b0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= 1'b0;
          if (enable && pair_ready) begin
            left_rd_en  <= 1'b1;
            right_rd_en <= 1'b1;
            pair        <= {left_s, right_s};
            stopping    <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          div_cnt <= wrap ? '0 : div_cnt + 1'b1;
          if (wrap)
            i2s_bclk <= ~i2s_bclk;
          if (tick) begin
            if (stopping) begin
              state     <= IDLE;
              busy      <= 1'b0;
              bit_cnt   <= '0;
              i2s_lrclk <= 1'b0;
              i2s_sdata <= 1'b0;
            end else begin
              i2s_sdata <= pair[LAST_SLOT - bit_cnt];
              i2s_lrclk <= (next_cnt >= HALF_SLOT);
              bit_cnt   <= next_cnt;
              if (frame_end) begin
                if (!enable) begin
                  stopping <= 1'b1;
                end else if (pair_ready) begin
                  left_rd_en  <= 1'b1;
                  right_rd_en <= 1'b1;
                  pair        <= {left_s, right_s};
                end else begin
                  underflow <= 1'b1;
`ifdef I2S_UNDERFLOW_HOLD_EN
                  pair <= pair;
`else
                  pair <= '0;
`endif
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: S=16, BCLK_DIV=2, SHIFT=0, FIFO models on both channels.
`timescale 1ns/1ps
module tb_i2s_audio_tx;
  localparam int DW         = 32;
  localparam int SB         = 16;
  localparam int DIV        = 2;
  localparam int FRAME_CLKS = 2 * SB * 2 * DIV;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] left_in;
  logic          left_empty;
  logic          left_rd_en;
  logic [DW-1:0] right_in;
  logic          right_empty;
  logic          right_rd_en;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          busy;
  logic          underflow;

  logic [31:0] sat_in;
  logic [15:0] sat_out;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [31:0]   exp_q[$];

  int errors = 0;
  int checks = 0;
  int pops_l = 0;
  int pops_r = 0;
  int mon_abs = -1;
  int cyc = 0;
  int last_slot0_cyc = 0;

  always #5 clock = ~clock;

  i2s_audio_tx #(.DATA_WIDTH(DW), .SAMPLE_BITS(SB), .SHIFT(0), .BCLK_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left_in(left_in), .left_empty(left_empty), .left_rd_en(left_rd_en),
    .right_in(right_in), .right_empty(right_empty), .right_rd_en(right_rd_en),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .busy(busy), .underflow(underflow)
  );

  audio_sat #(.DATA_WIDTH(32), .SAMPLE_BITS(16), .SHIFT(4)) u_sat4 (.din(sat_in), .dout(sat_out));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {25'b0, i2s_bclk, i2s_lrclk, i2s_sdata, busy, underflow, left_rd_en, right_rd_en};
  endfunction

  task automatic fifo_outs();
    left_empty  = (lq.size() == 0);
    right_empty = (rq.size() == 0);
    left_in     = left_empty  ? '0 : lq[0];
    right_in    = right_empty ? '0 : rq[0];
  endtask

  task automatic push_left(input logic [31:0] v);
    lq.push_back(v);
    fifo_outs();
  endtask

  task automatic push_right(input logic [31:0] v);
    rq.push_back(v);
    fifo_outs();
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r, input logic [31:0] exp);
    lq.push_back(l);
    rq.push_back(r);
    exp_q.push_back(exp);
    fifo_outs();
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_slot(input int frame, input int slot, input int budget);
    int n = 0;
    while (mon_abs != frame * 32 + slot && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_slot timeout: got slot %0d, required %0d", mon_abs, frame * 32 + slot);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout: got busy=%0b, required 0", busy);
    end
  endtask

  // FIFO model: rd_en seen high mid-cycle pops the head at the following rising edge.
  initial begin
    logic pl;
    logic pr;
    logic prev_pop = 1'b0;
    forever begin
      @(negedge clock);
      pl = left_rd_en;
      pr = right_rd_en;
      if (pl || pr) begin
        check("pop_together", {31'b0, pl}, {31'b0, pr});
        check("pop_single_cycle", {31'b0, prev_pop}, 32'd0);
        check("pop_nonempty", {31'b0, (lq.size() != 0) && (rq.size() != 0)}, 32'd1);
        prev_pop = 1'b1;
        @(posedge clock);
        #1;
        if (pl && lq.size() != 0) begin
          void'(lq.pop_front());
          pops_l++;
        end
        if (pr && rq.size() != 0) begin
          void'(rq.pop_front());
          pops_r++;
        end
        fifo_outs();
      end else begin
        prev_pop = 1'b0;
      end
    end
  end

  // Monitor: captures sdata/lrclk at each bclk rise and retires a frame at the next slot 0.
  initial begin
    logic [31:0] sr = '0;
    logic [31:0] lr = '0;
    logic bclk_prev = 1'b0;
    int slot;
    int frame;
    forever begin
      @(negedge clock);
      cyc++;
      if (!busy) begin
        mon_abs = -1;
      end else if (i2s_bclk && !bclk_prev) begin
        mon_abs++;
        sr    = {sr[30:0], i2s_sdata};
        lr    = {lr[30:0], i2s_lrclk};
        slot  = mon_abs % 32;
        frame = mon_abs / 32;
        if (slot == 0) begin
          if (frame == 0) begin
            check("first_slot0", {31'b0, i2s_sdata}, 32'd0);
          end else begin
            check("frame_period", 32'(cyc - last_slot0_cyc), 32'(FRAME_CLKS));
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_data: got unexpected frame %h, expected none", sr);
            end else begin
              check("frame_data", sr, exp_q.pop_front());
            end
          end
          last_slot0_cyc = cyc;
        end
        if (slot == 31)
          check("lrclk_pattern", lr, 32'h0000_FFFF);
      end
      bclk_prev = i2s_bclk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seen = '0;
    logic        busy_seen = 1'b0;
    reset  = 1'b1;
    enable = 1'b1;
    sat_in = '0;
    fifo_outs();

    // Reset held with enable high and empty FIFOs.
    repeat (200) begin
      @(negedge clock);
      seen |= outs();
    end
    check("reset_outputs_quiet", seen, 32'd0);
    step();
    reset = 1'b0;
    repeat (20) step();
    check("idle_when_empty", outs(), 32'd0);

    // Shift-by-4 converter.
    sat_in = 32'h0001_0000; #1 check("sat_shift4_pos", {16'h0, sat_out}, 32'h0000_1000);
    sat_in = 32'h7FFF_FFFF; #1 check("sat_shift4_max", {16'h0, sat_out}, 32'h0000_7FFF);
    sat_in = 32'hFFFF_FFF0; #1 check("sat_shift4_neg", {16'h0, sat_out}, 32'h0000_FFFF);

    // Three back-to-back frames: plain data, then saturation, then exact limits.
    step();
    push_pair(32'h0000_1234, 32'hFFFF_FFFE, 32'h1234_FFFE);
    push_pair(32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_8000);
    push_pair(32'hFFFF_8000, 32'h0000_8000, 32'h8000_7FFF);
    wait_slot(2, 10, 2000);
    enable = 1'b0;
    wait_idle(1000);
    check("stop_outputs", outs(), 32'd0);
    repeat (50) step();
    check("pops_left_t2", 32'(pops_l), 32'd3);
    check("pops_right_t2", 32'(pops_r), 32'd3);
    check("frames_left_t2", 32'(exp_q.size()), 32'd0);

    // Single pair, then the FIFOs run dry.
    push_pair(32'h0000_1234, 32'hFFFF_FFFE, 32'h1234_FFFE);
`ifdef I2S_UNDERFLOW_HOLD_EN
    exp_q.push_back(32'h1234_FFFE);
`else
    exp_q.push_back(32'h0000_0000);
`endif
    enable = 1'b1;
    wait_slot(1, 10, 2000);
    enable = 1'b0;
    wait_idle(1000);
    check("underflow_set", {31'b0, underflow}, 32'd1);
    repeat (300) step();
    check("underflow_sticky", {31'b0, underflow}, 32'd1);
    check("pops_left_t3", 32'(pops_l), 32'd4);
    check("frames_left_t3", 32'(exp_q.size()), 32'd0);

    // Left ready, right empty: must stay idle until both are present.
    push_left(32'h0000_0001);
    enable = 1'b1;
    repeat (500) begin
      step();
      busy_seen |= busy;
    end
    check("no_start_one_empty", {31'b0, busy_seen}, 32'd0);
    check("no_pop_one_empty", 32'(pops_l + pops_r), 32'd8);
    push_right(32'h8000_0000);
    exp_q.push_back(32'h0001_8000);
    wait_slot(0, 10, 2000);
    enable = 1'b0;
    wait_idle(1000);
    check("pops_left_t4", 32'(pops_l), 32'd5);
    check("pops_right_t4", 32'(pops_r), 32'd5);
    check("frames_left_t4", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the second frame.
    push_pair(32'h0000_00FF, 32'hFFFF_FF00, 32'h00FF_FF00);
    push_pair(32'h0000_5555, 32'h0000_AAAA, 32'h5555_7FFF);
    enable = 1'b1;
    wait_slot(1, 20, 2000);
    reset = 1'b1;
    #1 check("reset_mid_frame", outs(), 32'd0);
    check("frames_pending_t5", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (20) step();
    reset  = 1'b0;
    enable = 1'b0;
    repeat (20) step();
    check("pops_left_t5", 32'(pops_l), 32'd7);
    check("underflow_cleared", {31'b0, underflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Reads stereo audio from the two audio output FIFOs (left and right) of the FM radio pipeline and serializes it as a standard I2S master stream: bclk, lrclk and sdata.
- It is the consumer at the far end of the audio FIFO interface.
- Each 32-bit fixed-point audio word is shifted, saturated to SAMPLE_BITS, and sent MSB first with the I2S one-bit delay after each lrclk edge.

Parameters:
- DATA_WIDTH, 32, width of FIFO audio words (signed fixed-point).
- SAMPLE_BITS, 16, bits sent per channel slot (2..DATA_WIDTH).
- SHIFT, 0, arithmetic right shift applied before saturation (0..DATA_WIDTH-1).
- BCLK_DIV, 4, system clocks per bclk half-period (>=1).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- enable, in, 1, run request; sampled at frame boundaries.
- left_in, in, DATA_WIDTH, left FIFO dout (first-word-fall-through: valid whenever left_empty=0).
- left_empty, in, 1, left FIFO empty.
- left_rd_en, out, 1, left FIFO pop.
- right_in, in, DATA_WIDTH, right FIFO dout (first-word-fall-through).
- right_empty, in, 1, right FIFO empty.
- right_rd_en, out, 1, right FIFO pop.
- i2s_bclk, out, 1, bit clock.
- i2s_lrclk, out, 1, word select (0 = left, 1 = right).
- i2s_sdata, out, 1, serial data, changes on bclk falling edges.
- busy, out, 1, high in RUN.
- underflow, out, 1, sticky; set when a frame had no data; cleared only by reset.

Behaviour:
- Reset: asynchronous, active-high; one clock. All outputs are 0 during and after reset; FSM enters IDLE; counters and holding registers are cleared.
- Sample conversion: s = left_in >>> SHIFT (arithmetic). Clamp s to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1], then keep the low SAMPLE_BITS bits. Right channel is identical.
- Timing: div_cnt runs 0..BCLK_DIV-1 in RUN only. At wrap, bclk toggles. The cycle in which bclk goes 1->0 is the "tick". bclk period = 2*BCLK_DIV clocks.
- Frame: 2*SAMPLE_BITS slots, indexed by bit_cnt, which advances on each tick.
  - lrclk = 0 for slots 0..S-1 and 1 for slots S..2S-1 (S = SAMPLE_BITS).
  - sdata in slot n carries bit n-1 of the stream {L[MSB..LSB], R[MSB..LSB]}.
  - Slot 0 carries the R LSB of the previous frame, or 0 for the first frame after IDLE.
- FSM states:
  - IDLE: bclk = lrclk = sdata = 0. When enable=1, left_empty=0 and right_empty=0: pulse left_rd_en and right_rd_en together for one cycle, latch both converted words, set bit_cnt=0, go to RUN. The first bclk rising edge is BCLK_DIV clocks later.
  - RUN, frame-boundary tick (bit_cnt 2S-1 -> 0):
    - enable=1 and both FIFOs non-empty: pop both in that cycle, latch new pair, continue with no gap.
    - enable=1 and either FIFO empty: no pop, latch zeros, set underflow, continue.
    - enable=0: send the final slot 0 (previous R LSB), then go to IDLE at the next tick with bclk low.
- Pop rules: never pop one FIFO without the other; never pop when either is empty; at most one pop per frame; rd_en is never held for more than one cycle.
- enable deasserted mid-frame: the current frame completes unchanged.
- Reset mid-frame: outputs go to 0 immediately; no pop.

Optional Feature:
- Macro I2S_UNDERFLOW_HOLD_EN.
- Defined: on underflow, the previous pair is re-sent instead of zeros, and underflow is still set.
- Undefined: zeros are sent.

Decomposition:
- Shared package macros: state typedef (IDLE, RUN) and default constants I2S_SAMPLE_BITS=16 and I2S_BCLK_DIV=4.
- One combinational sub-module audio_sat (shift + saturate, parameterised by DATA_WIDTH, SAMPLE_BITS, SHIFT), instanced once per channel.

Test Plan:
- Reset with both FIFOs empty and enable=1 for 200 clocks -> all outputs 0, no rd_en.
- S=16, DIV=2, SHIFT=0; push L=0x0000_1234, R=0xFFFF_FFFE -> one rd_en pulse per FIFO. Captured on bclk rising edges: slots 1..16 = 0x1234, 17..32 = 0xFFFE. Frame = 128 clocks.
- Saturation: L=0x0001_0000 -> 0x7FFF; R=0xFFFF_0000 -> 0x8000. With SHIFT=4, L=0x0001_0000 -> 0x1000.
- Single pair, then FIFOs stay empty -> second frame slot 0 = 0 (R LSB), slots 1..32 all 0, underflow=1 and stays 1. With I2S_UNDERFLOW_HOLD_EN defined -> frame repeats 0x1234/0xFFFE.
- Left non-empty, right empty for 500 clocks -> no pop, remains IDLE. Then push right -> both pop in the same cycle.
- Drop enable at slot 10 -> frame completes to slot 0, goes IDLE with bclk=0, no further pops. Assert reset at slot 20 of a later frame -> outputs 0 within the same cycle.
